mem_access_unit: RTL

- Initiator-side controller for the processor's level-sensitive data RAM (32 words x 32 bits; combinational read; writes while its write strobe is high).
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Drives the RAM's address, write-data and read/write strobes for a fixed access window, then returns read data or a completion over a valid/ready response channel.
- Sits between the execute/memory stage and the RAM.

---
 rtl/mem_access_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator-side controller for the level-sensitive data RAM.
// Accepts one load/store at a time, drives the RAM address/data/strobes for a
// fixed window of WAIT_CYCLES+1 cycles, then presents a registered response.
module mem_access_unit #(
  parameter int MEM_WORDS   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in,
  output logic        CONTROL_MEM_READ,
  output logic        CONTROL_MEM_WRITE,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic        in_range;

  // Full 32-bit range compare so large addresses never alias into the RAM.
  assign in_range = (req_addr < 32'(MEM_WORDS));

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = in_range ? ACCESS : RESP;
      ACCESS:  if (wait_cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs: RAM interface, wait counter and response channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_err          <= 1'b0;
      mem_address       <= '0;
      mem_in            <= '0;
      CONTROL_MEM_READ  <= 1'b0;
      CONTROL_MEM_WRITE <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (in_range) begin
              mem_address       <= req_addr;
              mem_in            <= req_wdata;
              CONTROL_MEM_WRITE <= req_write;
              CONTROL_MEM_READ  <= !req_write;
              wait_cnt          <= 4'(WAIT_CYCLES);
            end else begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            resp_rdata        <= CONTROL_MEM_READ ? mem_out : '0;
            resp_err          <= 1'b0;
            resp_valid        <= 1'b1;
            CONTROL_MEM_READ  <= 1'b0;
            CONTROL_MEM_WRITE <= 1'b0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
